// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte type, PRGA state encoding and default message length.
// The init and KSA stages import the same package.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int MSG_LEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_I,
    ST_WT_I,
    ST_LD_I,
    ST_RD_J,
    ST_WT_J,
    ST_LD_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_WT_F,
    ST_LD_F,
    ST_WR_OUT,
    ST_DONE
  } prga_state_t;

  // Printable-key test: lowercase letter or space.
  function automatic logic is_key_char(byte_t b);
    return (b == 8'd32) || ((b >= 8'd97) && (b <= 8'd122));
  endfunction

endpackage

// File: rtl/prga_decrypt_if.sv
// Memory-side bus of the PRGA stage: S-memory, encrypted ROM and decrypted RAM.
interface prga_decrypt_if;
  import rc4_pkg::*;

  byte_t s_addr;
  byte_t s_wdata;
  logic  s_wren;
  byte_t s_rdata;
  byte_t rom_addr;
  byte_t rom_rdata;
  byte_t ram_addr;
  byte_t ram_wdata;
  logic  ram_wren;

  // The decryptor drives addresses and write strobes.
  modport master (
    output s_addr, s_wdata, s_wren, rom_addr, ram_addr, ram_wdata, ram_wren,
    input  s_rdata, rom_rdata
  );

  // The memories answer with registered read data.
  modport slave (
    input  s_addr, s_wdata, s_wren, rom_addr, ram_addr, ram_wdata, ram_wren,
    output s_rdata, rom_rdata
  );
endinterface

// File: rtl/prga_char_check.sv
// Combinational check that a decrypted byte is a plausible key character.
module prga_char_check
  import rc4_pkg::*;
(
  input  byte_t data,
  output logic  valid
);
  assign valid = is_key_char(data);
endmodule

// File: rtl/prga_decrypt.sv
// RC4 PRGA stage: generates keystream from S, XORs it with the encrypted ROM
// and writes the plaintext to RAM, 12 cycles per byte.
// Optional feature macro: PRGA_KEYCHECK_EN (abort on a non-key character).
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  prga_decrypt_if.master  mem,
  output logic            busy,
  output logic            done,
  output logic            key_bad
);

  localparam byte_t LAST_K = byte_t'(MSG_LEN - 1);

  prga_state_t state_reg, state_next;
  byte_t i_reg, j_reg, k_reg, si_reg, sj_reg, f_reg, enc_reg;
  byte_t out_byte;
  logic  byte_ok;

  assign out_byte = f_reg ^ enc_reg;

`ifdef PRGA_KEYCHECK_EN
  logic key_bad_reg;

  prga_char_check u_char_check (
    .data  (out_byte),
    .valid (byte_ok)
  );

  // Sticky flag for a rejected byte, cleared by each new run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      key_bad_reg <= 1'b0;
    else if ((state_reg == ST_IDLE || state_reg == ST_DONE) && start)
      key_bad_reg <= 1'b0;
    else if (state_reg == ST_WR_OUT && !byte_ok)
      key_bad_reg <= 1'b1;
  end

  assign key_bad = key_bad_reg;
`else
  assign byte_ok = 1'b1;
  assign key_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state: fixed 12-step walk per byte, start only honoured when idle/done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_RD_I;
      ST_RD_I:   state_next = ST_WT_I;
      ST_WT_I:   state_next = ST_LD_I;
      ST_LD_I:   state_next = ST_RD_J;
      ST_RD_J:   state_next = ST_WT_J;
      ST_WT_J:   state_next = ST_LD_J;
      ST_LD_J:   state_next = ST_WR_I;
      ST_WR_I:   state_next = ST_WR_J;
      ST_WR_J:   state_next = ST_RD_F;
      ST_RD_F:   state_next = ST_WT_F;
      ST_WT_F:   state_next = ST_LD_F;
      ST_LD_F:   state_next = ST_WR_OUT;
      ST_WR_OUT: state_next = (!byte_ok || k_reg == LAST_K) ? ST_DONE : ST_RD_I;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath: indices and latched read data; sums wrap at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_reg   <= '0;
      j_reg   <= '0;
      k_reg   <= '0;
      si_reg  <= '0;
      sj_reg  <= '0;
      f_reg   <= '0;
      enc_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            i_reg <= '0;
            j_reg <= '0;
            k_reg <= '0;
          end
        end
        ST_RD_I: i_reg <= i_reg + 8'd1;
        ST_LD_I: begin
          si_reg <= mem.s_rdata;
          j_reg  <= j_reg + mem.s_rdata;
        end
        ST_LD_J: sj_reg <= mem.s_rdata;
        ST_LD_F: begin
          f_reg   <= mem.s_rdata;
          enc_reg <= mem.rom_rdata;
        end
        ST_WR_OUT: if (byte_ok && k_reg != LAST_K) k_reg <= k_reg + 8'd1;
        default: ;
      endcase
    end
  end

  // Outputs: read addresses are held through the wait and load states so the
  // registered memory output stays stable until it is latched.
  always_comb begin
    busy          = 1'b1;
    done          = 1'b0;
    mem.s_addr    = '0;
    mem.s_wdata   = '0;
    mem.s_wren    = 1'b0;
    mem.rom_addr  = k_reg;
    mem.ram_addr  = '0;
    mem.ram_wdata = '0;
    mem.ram_wren  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy         = 1'b0;
        mem.rom_addr = '0;
      end
      ST_DONE: begin
        busy         = 1'b0;
        done         = 1'b1;
        mem.rom_addr = '0;
      end
      ST_RD_I:                   mem.s_addr = i_reg + 8'd1;
      ST_WT_I, ST_LD_I:          mem.s_addr = i_reg;
      ST_RD_J, ST_WT_J, ST_LD_J: mem.s_addr = j_reg;
      ST_WR_I: begin
        mem.s_addr  = i_reg;
        mem.s_wdata = sj_reg;
        mem.s_wren  = 1'b1;
      end
      ST_WR_J: begin
        mem.s_addr  = j_reg;
        mem.s_wdata = si_reg;
        mem.s_wren  = 1'b1;
      end
      ST_RD_F, ST_WT_F, ST_LD_F: mem.s_addr = si_reg + sj_reg;
      ST_WR_OUT: begin
        mem.ram_addr  = k_reg;
        mem.ram_wdata = out_byte;
        mem.ram_wren  = byte_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Scoreboard bench for prga_decrypt: byte-level RC4 model, queued RAM writes and done times.
module tb_prga_decrypt;
  import rc4_pkg::*;

  localparam int ML = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, key_bad;
  int   cyc = 0;

  prga_decrypt_if bus ();

  prga_decrypt #(.MSG_LEN(ML)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mem     (bus.master),
    .busy    (busy),
    .done    (done),
    .key_bad (key_bad)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories with registered reads.
  byte_t s_mem [256];
  byte_t enc_arr [256];
  byte_t ram [256];
  always @(posedge clk) begin
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wdata;
    bus.s_rdata   <= s_mem[bus.s_addr];
    bus.rom_rdata <= enc_arr[bus.rom_addr];
    if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state.
  byte_t s_init [256];
  byte_t ms [256];
  byte_t ks [256];
  int    m_n;
  bit    m_bad;
  logic [15:0] wr_q [$];
  int    done_q [$];

  // Plain RC4 PRGA over nb bytes starting from s_init.
  task automatic keystream(input int nb);
    int i = 0, j = 0, a, b;
    byte_t t;
    for (int x = 0; x < 256; x++) ms[x] = s_init[x];
    for (int k = 0; k < nb; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(ms[i])) % 256;
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      a = ms[i]; b = ms[j];
      ks[k] = ms[(a + b) % 256];
    end
  endtask

  // Expected plaintext writes; stops at a rejected byte when the key check is built in.
  task automatic model_run(input int limit);
    byte_t o;
    keystream(ML);
    m_n = 0;
    m_bad = 1'b0;
    for (int k = 0; k < ML; k++) begin
      o = ks[k] ^ enc_arr[k];
      m_n++;
`ifdef PRGA_KEYCHECK_EN
      if (!(o == 8'd32 || (o >= 8'd97 && o <= 8'd122))) begin
        m_bad = 1'b1;
        break;
      end
`endif
      if (k < limit) wr_q.push_back({k[7:0], o});
    end
    keystream(m_n);
  endtask

  // Monitor: every RAM write and every rising done is matched against the queues.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.ram_wren) begin
      check("wr_q_nonempty", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) check("ram_write", {bus.ram_addr, bus.ram_wdata}, 32'(wr_q.pop_front()));
      check("key_bad_on_write", 32'(key_bad), 32'd0);
    end
    if (done && !done_prev) begin
      check("done_q_nonempty", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) check("done_cycle", cyc, done_q.pop_front());
    end
    done_prev <= done;
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_wren"}, {30'd0, bus.s_wren, bus.ram_wren}, 32'd0);
    check({tag, "_addrs"}, {8'd0, bus.s_addr, bus.rom_addr, bus.ram_addr}, 32'd0);
    check({tag, "_data"}, {16'd0, bus.s_wdata, bus.ram_wdata}, 32'd0);
  endtask

  // One decryption run; abort_bytes>0 resets in WT_J of that byte.
  task automatic do_run(input string tag, input int abort_bytes, input bit mid_start);
    int diffs;
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = s_init[x];
      ram[x] = 8'h00;
    end
    model_run(abort_bytes > 0 ? abort_bytes : ML);
    @(negedge clk);
    if (abort_bytes == 0) done_q.push_back(cyc + 1 + 12 * m_n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (abort_bytes > 0) begin
      repeat (12 * abort_bytes + 4) @(posedge clk);
      #1 reset = 1'b1;
      #1 check_outputs_zero({tag, "_rst"});
      check({tag, "_partial_writes_left"}, 32'(wr_q.size()), 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      return;
    end
    if (mid_start) begin
      repeat (100) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int c = 0; c < 12 * ML + 40; c++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_done_reached"}, 32'(done), 32'd1);
    check({tag, "_key_bad"}, 32'(key_bad), 32'(m_bad));
    check({tag, "_writes_left"}, 32'(wr_q.size()), 32'd0);
    diffs = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) diffs++;
    check({tag, "_s_final"}, diffs, 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, {busy, done}, 32'd1);
    $display("run %s: bytes=%0d key_bad=%0d ram0=%02h ram1=%02h", tag, m_n, key_bad, ram[0], ram[1]);
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_init[x] = byte_t'(x);
  endtask

  // enc chosen so every plaintext byte is a lowercase letter.
  task automatic set_letter_enc();
    keystream(ML);
    for (int k = 0; k < ML; k++) enc_arr[k] = ks[k] ^ byte_t'(97 + $urandom_range(0, 25));
  endtask

  initial begin
    for (int x = 0; x < 256; x++) enc_arr[x] = 8'h00;
    #2 check_outputs_zero("reset");
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle");

    // Identity S, zero ciphertext: keystream 02, 05, ...
    set_identity();
    do_run("identity", 0, 1'b0);
`ifdef PRGA_KEYCHECK_EN
    check("identity_ram0", 32'(ram[0]), 32'h00);
`else
    check("identity_ram0", 32'(ram[0]), 32'h02);
    check("identity_ram1", 32'(ram[1]), 32'h05);
`endif

    // Identity S, enc[0]=0x63 decrypts to 'a'.
    enc_arr[0] = 8'h63;
    do_run("letter_a", 0, 1'b0);
    check("letter_a_ram0", 32'(ram[0]), 32'h61);

    // Random S contents and ciphertext.
    for (int r = 0; r < 2; r++) begin
      for (int x = 0; x < 256; x++) begin
        s_init[x] = byte_t'($urandom_range(0, 255));
        enc_arr[x] = byte_t'($urandom_range(0, 255));
      end
      do_run($sformatf("random%0d", r), 0, 1'b0);
    end

    // Random permutation, letter plaintext, start pulsed while busy.
    set_identity();
    for (int x = 255; x > 0; x--) begin
      int y = $urandom_range(0, x);
      byte_t t = s_init[x];
      s_init[x] = s_init[y];
      s_init[y] = t;
    end
    set_letter_enc();
    do_run("mid_start", 0, 1'b1);

    // Reset in WT_J of byte 5, then a clean restart from restored S.
    do_run("abort", 5, 1'b0);
    do_run("restart", 0, 1'b0);

    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule
